pc_unit: RTL and testbench

- Parametrised program-counter unit for the multi-cycle CPU.
- Holds the current instruction address and precomputes the sequential successor.
- Selects the next PC from four sources: sequential, relative branch, absolute jump, register.
- Maintains a small circular return-address stack (RAS) for call/return. Sits between the control unit / ALU and the instruction memory address port.

---
 rtl/pc_unit.sv | 151 +++++++++++++++
 tb/tb_pc_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with next-PC select, alignment check and circular return-address stack
module pc_unit #(
   parameter int               WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_ADDR = '0,
   parameter int               STEP       = 4,
   parameter int               RAS_DEPTH  = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PCWre,
   input  logic [1:0]       PCSrc,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] target,
   input  logic [WIDTH-1:0] rs_val,
   input  logic             call,
   input  logic             ret,
   output logic [WIDTH-1:0] addr,
   output logic [WIDTH-1:0] PC4,
   output logic             ras_empty,
   output logic             ras_full,
   output logic             ras_underflow,
   output logic             misalign
);

   // Shift that turns an instruction count into a byte offset.
   localparam int SH = $clog2(STEP);
   // Stack pointer indexes the slot the next push lands in; the count needs one extra bit to reach RAS_DEPTH.
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
   localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);
   localparam logic [CW-1:0]    CNT_FULL = CW'(RAS_DEPTH);
   localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
   localparam logic [PW-1:0]    PTR_ONE  = PW'(1);

   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] pc4_q, pc4_d;
   logic [WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [WIDTH-1:0] ras_d [RAS_DEPTH];
   logic [PW-1:0]    sp_q, sp_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             uf_q, uf_d;
   logic             mis_q, mis_d;

   logic [WIDTH-1:0] src_pc;
   logic [WIDTH-1:0] nxt;
   logic [WIDTH-1:0] nxt_aligned;
   logic [WIDTH-1:0] top_val;
   logic [PW-1:0]    top_idx;
   logic             empty;
   logic             full;
   logic             pop;
   logic             nxt_misaligned;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_FULL);
   // The pointer wraps naturally because RAS_DEPTH is a power of two; when full it also addresses the oldest entry.
   assign top_idx = sp_q - PTR_ONE;
   assign top_val = ras_q[top_idx];
   assign pop     = ret && !empty;

   // Select the candidate next PC from PCSrc; branch offsets are in instructions, so scale to bytes.
   always_comb begin
      src_pc = pc4_q;
      case (PCSrc)
         2'b00:   src_pc = pc4_q;
         2'b01:   src_pc = pc4_q + (imm << SH);
         2'b10:   src_pc = target;
         default: src_pc = rs_val;
      endcase
   end

   // A return overrides PCSrc; an empty stack falls back to the sequential address.
   always_comb begin
      nxt = src_pc;
      if (ret) begin
         nxt = empty ? pc4_q : top_val;
      end
      nxt_misaligned = |(nxt & LOW_MASK);
      nxt_aligned    = nxt & ~LOW_MASK;
   end

   // PC, flag next-state: everything holds unless PCWre; the underflow flag is a one-update pulse.
   always_comb begin
      addr_d = addr_q;
      pc4_d  = pc4_q;
      uf_d   = 1'b0;
      mis_d  = mis_q;
      if (PCWre) begin
         addr_d = nxt_aligned;
         pc4_d  = nxt_aligned + STEP_W;
         uf_d   = ret && empty;
         mis_d  = mis_q | nxt_misaligned;
      end
   end

   // Stack next-state: call+ret on a non-empty stack swaps the top in place, otherwise push or pop.
   always_comb begin
      ras_d = ras_q;
      sp_d  = sp_q;
      cnt_d = cnt_q;
      if (PCWre) begin
         if (call && pop) begin
            ras_d[top_idx] = pc4_q;
         end else if (call) begin
            ras_d[sp_q] = pc4_q;
            sp_d        = sp_q + PTR_ONE;
            if (!full) begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end else if (pop) begin
            sp_d  = sp_q - PTR_ONE;
            cnt_d = cnt_q - CNT_ONE;
         end
      end
   end

   // State register with synchronous active-low reset that discards the stack contents.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         addr_q <= RESET_ADDR;
         pc4_q  <= RESET_ADDR + STEP_W;
         sp_q   <= '0;
         cnt_q  <= '0;
         uf_q   <= 1'b0;
         mis_q  <= 1'b0;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= '0;
         end
      end else begin
         addr_q <= addr_d;
         pc4_q  <= pc4_d;
         sp_q   <= sp_d;
         cnt_q  <= cnt_d;
         uf_q   <= uf_d;
         mis_q  <= mis_d;
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_q[i] <= ras_d[i];
         end
      end
   end

   assign addr          = addr_q;
   assign PC4           = pc4_q;
   assign ras_empty     = empty;
   assign ras_full      = full;
   assign ras_underflow = uf_q;
   assign misalign      = mis_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed vector table plus randomized model comparison for pc_unit
module tb_pc_unit;

   localparam int STEP  = 4;
   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        PCWre = 1'b0;
   logic [1:0]  PCSrc = 2'b00;
   logic [31:0] imm = '0, target = '0, rs_val = '0;
   logic        call = 1'b0, ret = 1'b0;
   logic [31:0] addr, PC4;
   logic        ras_empty, ras_full, ras_underflow, misalign;

   int compared = 0;
   int mismatched = 0;

   pc_unit #(.WIDTH(32), .RESET_ADDR(32'h0), .STEP(STEP), .RAS_DEPTH(DEPTH)) dut (
      .CLK(CLK), .RST(RST), .PCWre(PCWre), .PCSrc(PCSrc), .imm(imm),
      .target(target), .rs_val(rs_val), .call(call), .ret(ret),
      .addr(addr), .PC4(PC4), .ras_empty(ras_empty), .ras_full(ras_full),
      .ras_underflow(ras_underflow), .misalign(misalign)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        rst, we;
      logic [1:0]  src;
      logic [31:0] imm, tgt, rs;
      logic        call, ret;
      logic [31:0] e_addr, e_pc4;
      logic        e_empty, e_full, e_uf, e_mis;
   } vec_t;

   vec_t tbl[$];

   // rst here is the RST pin level (0 = reset)
   function automatic vec_t v(logic rst, logic we, logic [1:0] src, logic [31:0] im,
                              logic [31:0] tg, logic [31:0] rs, logic c, logic r,
                              logic [31:0] ea, logic [31:0] ep, logic ee, logic ef,
                              logic eu, logic em);
      vec_t x;
      x.rst = rst; x.we = we; x.src = src; x.imm = im; x.tgt = tg; x.rs = rs;
      x.call = c; x.ret = r; x.e_addr = ea; x.e_pc4 = ep;
      x.e_empty = ee; x.e_full = ef; x.e_uf = eu; x.e_mis = em;
      return x;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic we, input logic [1:0] src,
                        input logic [31:0] im, input logic [31:0] tg, input logic [31:0] rs,
                        input logic c, input logic r);
      RST = rst; PCWre = we; PCSrc = src; imm = im; target = tg; rs_val = rs;
      call = c; ret = r;
      @(posedge CLK);
      #1;
   endtask

   // Reference model: the stack is a list with the top at the back, oldest at the front.
   logic [31:0] m_addr, m_pc4;
   logic [31:0] m_ras[$];
   logic        m_uf, m_mis;

   task automatic model_step(input logic rst, input logic we, input logic [1:0] src,
                             input logic [31:0] im, input logic [31:0] tg, input logic [31:0] rs,
                             input logic c, input logic r);
      logic [31:0] nxt;
      logic [31:0] ret_addr;
      if (!rst) begin
         m_addr = 32'h0; m_pc4 = 32'h4; m_ras.delete(); m_uf = 1'b0; m_mis = 1'b0;
      end else if (!we) begin
         m_uf = 1'b0;
      end else begin
         ret_addr = m_pc4;
         case (src)
            2'b00: nxt = m_pc4;
            2'b01: nxt = m_pc4 + im * 32'(STEP);
            2'b10: nxt = tg;
            default: nxt = rs;
         endcase
         m_uf = 1'b0;
         if (r) begin
            if (m_ras.size() > 0) begin
               nxt = m_ras[$];
               void'(m_ras.pop_back());
            end else begin
               nxt = m_pc4;
               m_uf = 1'b1;
            end
         end
         if (c) begin
            m_ras.push_back(ret_addr);
            if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
         end
         if ((nxt % STEP) != 0) m_mis = 1'b1;
         nxt = nxt - (nxt % STEP);
         m_addr = nxt;
         m_pc4 = nxt + 32'(STEP);
      end
   endtask

   initial begin
      vec_t t;
      logic        r_rst, r_we, r_c, r_r;
      logic [1:0]  r_src;
      logic [31:0] r_imm, r_tg, r_rs;

      //           rst we src    imm           target        rs            c  r  addr          pc4           emp ful uf mis
      tbl.push_back(v(0, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h4,        1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h4,        32'h8,        1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h8,        32'hC,        1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'hC,        32'h10,       1, 0, 0, 0));
      tbl.push_back(v(0, 1, 2'b10, 32'h0,        32'h500,      32'h0,        1, 0, 32'h0,        32'h4,        1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h100,      32'h0,        0, 0, 32'h100,      32'h104,      1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b01, 32'hFFFFFFFE, 32'h0,        32'h0,        0, 0, 32'h0FC,      32'h100,      1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h2000,     32'h0,        0, 0, 32'h2000,     32'h2004,     1, 0, 0, 0));
      tbl.push_back(v(1, 0, 2'b10, 32'h0,        32'h3000,     32'h0,        1, 0, 32'h2000,     32'h2004,     1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h10,       32'h0,        0, 0, 32'h10,       32'h14,       1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h400,      32'h0,        1, 0, 32'h400,      32'h404,      0, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 32'h14,       32'h18,       1, 0, 0, 0));
      // five calls into a four-entry stack, then drain it and underflow
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h1000,     32'h0,        1, 0, 32'h1000,     32'h1004,     0, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h2000,     32'h0,        1, 0, 32'h2000,     32'h2004,     0, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h3000,     32'h0,        1, 0, 32'h3000,     32'h3004,     0, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h4000,     32'h0,        1, 0, 32'h4000,     32'h4004,     0, 1, 0, 0));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h5000,     32'h0,        1, 0, 32'h5000,     32'h5004,     0, 1, 0, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 32'h4004,     32'h4008,     0, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 32'h3004,     32'h3008,     0, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 32'h2004,     32'h2008,     0, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 32'h1004,     32'h1008,     1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h7000,     32'h0,        0, 1, 32'h1008,     32'h100C,     1, 0, 1, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h100C,     32'h1010,     1, 0, 0, 0));
      tbl.push_back(v(1, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 32'h100C,     32'h1010,     1, 0, 0, 0));
      // misalignment is sticky until reset
      tbl.push_back(v(1, 1, 2'b11, 32'h0,        32'h0,        32'h103,      0, 0, 32'h100,      32'h104,      1, 0, 0, 1));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h104,      32'h108,      1, 0, 0, 1));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h200,      32'h0,        0, 0, 32'h200,      32'h204,      1, 0, 0, 1));
      tbl.push_back(v(0, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h4,        1, 0, 0, 0));
      // address wrap and call+ret swap
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'hFFFFFFFC, 32'h0,        0, 0, 32'hFFFFFFFC, 32'h0,        1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 32'h0,        32'h4,        1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h4C,       32'h0,        0, 0, 32'h4C,       32'h50,       1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h1C,       32'h0,        1, 0, 32'h1C,       32'h20,       0, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b10, 32'h0,        32'h999,      32'h0,        1, 1, 32'h50,       32'h54,       0, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 32'h20,       32'h24,       1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        1, 1, 32'h24,       32'h28,       0, 0, 1, 0));
      tbl.push_back(v(1, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 32'h24,       32'h28,       1, 0, 0, 0));
      tbl.push_back(v(1, 1, 2'b01, 32'h3,        32'h0,        32'h0,        0, 0, 32'h34,       32'h38,       1, 0, 0, 0));

      foreach (tbl[i]) begin
         t = tbl[i];
         drive(t.rst, t.we, t.src, t.imm, t.tgt, t.rs, t.call, t.ret);
         chk($sformatf("vec%0d addr", i),      addr,                 t.e_addr);
         chk($sformatf("vec%0d PC4", i),       PC4,                  t.e_pc4);
         chk($sformatf("vec%0d empty", i),     32'(ras_empty),       32'(t.e_empty));
         chk($sformatf("vec%0d full", i),      32'(ras_full),        32'(t.e_full));
         chk($sformatf("vec%0d underflow", i), 32'(ras_underflow),   32'(t.e_uf));
         chk($sformatf("vec%0d misalign", i),  32'(misalign),        32'(t.e_mis));
      end

      // randomized run against the model, starting from a fresh reset
      model_step(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 2'b00, '0, '0, '0, 1'b0, 1'b0);
      for (int n = 0; n < 3000; n++) begin
         r_rst = ($urandom_range(0, 99) >= 2);
         r_we  = ($urandom_range(0, 9) >= 2);
         r_src = 2'($urandom_range(0, 3));
         r_imm = 32'($urandom_range(0, 127)) - 32'd64;
         if ($urandom_range(0, 9) == 0) r_imm = $urandom;
         r_tg  = $urandom;
         r_rs  = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            r_tg = r_tg & 32'hFFFFFFFC;
            r_rs = r_rs & 32'hFFFFFFFC;
         end
         r_c   = ($urandom_range(0, 3) == 0);
         r_r   = ($urandom_range(0, 3) == 0);
         model_step(r_rst, r_we, r_src, r_imm, r_tg, r_rs, r_c, r_r);
         drive(r_rst, r_we, r_src, r_imm, r_tg, r_rs, r_c, r_r);
         chk("rnd addr",      addr,               m_addr);
         chk("rnd PC4",       PC4,                m_pc4);
         chk("rnd empty",     32'(ras_empty),     32'(m_ras.size() == 0));
         chk("rnd full",      32'(ras_full),      32'(m_ras.size() == DEPTH));
         chk("rnd underflow", 32'(ras_underflow), 32'(m_uf));
         chk("rnd misalign",  32'(misalign),      32'(m_mis));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
